// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element MAC slice.
// Default geometry, psum/count widths, state encoding and a product sign-extension helper.
package pe_pkg;

    localparam int PE_WIDTH = 8;
    localparam int PE_KMAX  = 16;
    localparam int PSUM_W   = 3 * PE_WIDTH;
    localparam int CNT_W    = $clog2(PE_KMAX + 1);

    typedef logic signed [PSUM_W-1:0] psum_t;

    // Output-pending status is carried by the separate out_valid flag.
    typedef enum logic {
        ST_ACC = 1'b0
    } state_t;

    function automatic psum_t sext_prod(input logic signed [2*PE_WIDTH-1:0] prod);
        return {{PE_WIDTH{prod[2*PE_WIDTH-1]}}, prod};
    endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational MAC: o_psum = i_ifmap * i_filter + i_psum, two's-complement wrap at 3*WIDTH bits.
// Zero latency; no handshake.
module pe_mac #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0]   i_ifmap,
    input  logic signed [WIDTH-1:0]   i_filter,
    input  logic signed [3*WIDTH-1:0] i_psum,
    output logic signed [3*WIDTH-1:0] o_psum
);

    logic signed [2*WIDTH-1:0] w_prod;

    // Full-width product; the sized cast sign-extends before the wrapping add.
    assign w_prod = i_ifmap * i_filter;
    assign o_psum = (3*WIDTH)'(w_prod) + i_psum;

endmodule

// File: rtl/pe_mac_seq.sv
// Sequential PE front end: accumulates (ifmap, filter) beats into a psum, emits it on the last beat.
// Result valid 1 cycle after the terminating beat; input stalls while a result is held unaccepted.
module pe_mac_seq
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int KMAX  = PE_KMAX
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [WIDTH-1:0]        in_ifmap,
    input  logic signed [WIDTH-1:0]        in_filter,
    input  logic signed [3*WIDTH-1:0]      in_bias,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [3*WIDTH-1:0]      out_psum,
    output logic [$clog2(KMAX+1)-1:0]      out_count,
    output logic                           err_len
);

    localparam int PW = 3 * WIDTH;
    localparam int CW = $clog2(KMAX + 1);

    state_t                r_state, w_state_nxt;
    logic signed [PW-1:0]  r_acc, w_acc_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_first, w_first_nxt;
    logic                  r_out_vld, w_out_vld_nxt;
    logic signed [PW-1:0]  r_out_psum, w_out_psum_nxt;
    logic [CW-1:0]         r_out_cnt, w_out_cnt_nxt;
    logic                  r_err, w_err_nxt;

    logic                  w_accept;
    logic                  w_term;
    logic signed [PW-1:0]  w_base;
    logic signed [PW-1:0]  w_mac;
    logic [CW-1:0]         w_cnt_inc;

    assign in_ready  = !r_out_vld || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_base    = r_first ? in_bias : r_acc;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_term    = in_last || (r_cnt == CW'(KMAX - 1));

    pe_mac #(.WIDTH(WIDTH)) u_mac (
        .i_ifmap  (in_ifmap),
        .i_filter (in_filter),
        .i_psum   (w_base),
        .o_psum   (w_mac)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_first_nxt    = r_first;
        w_out_vld_nxt  = r_out_vld;
        w_out_psum_nxt = r_out_psum;
        w_out_cnt_nxt  = r_out_cnt;
        w_err_nxt      = r_err;
        case (r_state)
            ST_ACC: begin
                if (r_out_vld && out_ready) begin
                    w_out_vld_nxt = 1'b0;
                end
                if (w_accept) begin
                    w_acc_nxt   = w_mac;
                    w_cnt_nxt   = w_cnt_inc;
                    w_first_nxt = 1'b0;
                    // A terminating beat overrides the drain above so back-to-back results never bubble.
                    if (w_term) begin
                        w_out_psum_nxt = w_mac;
                        w_out_cnt_nxt  = w_cnt_inc;
                        w_out_vld_nxt  = 1'b1;
                        w_acc_nxt      = '0;
                        w_cnt_nxt      = '0;
                        w_first_nxt    = 1'b1;
                        if (!in_last) begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_first    <= 1'b1;
            r_out_vld  <= 1'b0;
            r_out_psum <= '0;
            r_out_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_first    <= w_first_nxt;
            r_out_vld  <= w_out_vld_nxt;
            r_out_psum <= w_out_psum_nxt;
            r_out_cnt  <= w_out_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign out_valid = r_out_vld;
    assign out_psum  = r_out_psum;
    assign out_count = r_out_cnt;
    assign err_len   = r_err;

endmodule
